// File: rtl/matmul_operand_loader_pkg.sv
// Shared sizes, operand byte type and FSM state encodings for the operand loader.
package matmul_operand_loader_pkg;

  localparam int ROWS      = 4;
  localparam int INNER     = 32;
  localparam int COLS      = 4;
  localparam int BUS_BYTES = 4;

  localparam int NA = ROWS * INNER / BUS_BYTES;
  localparam int NB = INNER * COLS / BUS_BYTES;

  localparam int NMAX  = (NA > NB) ? NA : NB;
  localparam int CNT_W = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef logic signed [7:0] int8_t;

  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD_A = 3'd1;
  localparam state_t LOAD_B = 3'd2;
  localparam state_t START  = 3'd3;
  localparam state_t WAIT   = 3'd4;

endpackage

// File: rtl/matmul_operand_loader_if.sv
// Byte-beat stream feeding the operand loader (valid/ready with end-of-frame marker).
interface matmul_operand_loader_if
  import matmul_operand_loader_pkg::*;
#(
  parameter int BEAT_BYTES = BUS_BYTES
);
  logic [BEAT_BYTES*8-1:0] in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/matmul_operand_loader_unpacker.sv
// Maps the current beat number onto per-element write enables of A and B.
module matmul_operand_loader_unpacker
  import matmul_operand_loader_pkg::*;
(
  input  logic             we,
  input  logic             sel_b,
  input  logic [CNT_W-1:0] beat,
  output logic             a_we [ROWS][INNER],
  output logic             b_we [INNER][COLS]
);

  // An element is written when its row-major byte index falls inside the current beat.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < INNER; c++) begin
        a_we[r][c] = we && !sel_b && (int'(beat) == (r * INNER + c) / BUS_BYTES);
      end
    end
    for (int r = 0; r < INNER; r++) begin
      for (int c = 0; c < COLS; c++) begin
        b_we[r][c] = we && sel_b && (int'(beat) == (r * COLS + c) / BUS_BYTES);
      end
    end
  end

endmodule

// File: rtl/matmul_operand_loader.sv
// Packs a byte stream into operand matrices A and B, kicks the multiplier and
// holds the operands until the multiplier signals completion.
//
//   state  | meaning
//   IDLE   | waiting for first beat of a frame
//   LOAD_A | receiving beats of A
//   LOAD_B | receiving beats of B, final beat must carry in_last
//   START  | one-cycle start pulse to the multiplier
//   WAIT   | operands frozen until a rising edge of mm_done
module matmul_operand_loader
  import matmul_operand_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  matmul_operand_loader_if.slave  beat_if,
  output logic                    mm_start,
  input  logic                    mm_done,
  output int8_t                   a_mat [ROWS][INNER],
  output int8_t                   b_mat [INNER][COLS],
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             accept;
  logic             final_beat;
  logic             frame_err;
  logic             a_we [ROWS][INNER];
  logic             b_we [INNER][COLS];

  assign beat_if.in_ready = !rst && (state == IDLE || state == LOAD_A || state == LOAD_B);
  assign accept     = beat_if.in_valid && beat_if.in_ready;
  assign final_beat = (state == LOAD_B) && (cnt == CNT_W'(NB - 1));
  // Any disagreement between in_last and the true frame end is a framing error.
  assign frame_err  = accept && (beat_if.in_last != final_beat);
  assign mm_start   = (state == START);
  assign busy       = (state != IDLE);

  matmul_operand_loader_unpacker u_unpacker (
    .we    (accept),
    .sel_b (state == LOAD_B),
    .beat  (cnt),
    .a_we  (a_we),
    .b_we  (b_we)
  );

  // Frame sequencing and beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (frame_err) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (NA == 1) begin
              state <= LOAD_B;
              cnt   <= '0;
            end else begin
              state <= LOAD_A;
              cnt   <= CNT_W'(1);
            end
          end
        end
        LOAD_A: begin
          if (accept) begin
            if (cnt == CNT_W'(NA - 1)) begin
              state <= LOAD_B;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (final_beat) begin
              state <= START;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (mm_done && !done_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Previous-cycle copy of mm_done so a level already high is not taken as completion.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= mm_done;
  end

  // Sticky framing error; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)            err <= 1'b0;
    else if (frame_err) err <= 1'b1;
    else if (err_clr)   err <= 1'b0;
  end

  // Operand storage, written only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < INNER; c++)
          a_mat[r][c] <= '0;
      for (int r = 0; r < INNER; r++)
        for (int c = 0; c < COLS; c++)
          b_mat[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < INNER; c++)
          if (a_we[r][c])
            a_mat[r][c] <= beat_if.in_data[8 * ((r * INNER + c) % BUS_BYTES) +: 8];
      for (int r = 0; r < INNER; r++)
        for (int c = 0; c < COLS; c++)
          if (b_we[r][c])
            b_mat[r][c] <= beat_if.in_data[8 * ((r * COLS + c) % BUS_BYTES) +: 8];
    end
  end

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Randomized bench for the operand loader with a frame-level reference model.
module tb_matmul_operand_loader;
  import matmul_operand_loader_pkg::*;

  localparam int A_BYTES = ROWS * INNER;
  localparam int B_BYTES = INNER * COLS;
  localparam int F_BEATS = (A_BYTES + B_BYTES) / BUS_BYTES;

  logic  clk = 1'b0;
  logic  rst;
  logic  mm_start;
  logic  mm_done;
  logic  busy;
  logic  err;
  logic  err_clr;
  int8_t a_mat [ROWS][INNER];
  int8_t b_mat [INNER][COLS];

  matmul_operand_loader_if bus ();

  matmul_operand_loader dut (
    .clk      (clk),
    .rst      (rst),
    .beat_if  (bus),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .a_mat    (a_mat),
    .b_mat    (b_mat),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: position within the frame plus start/wait flags.
  logic [7:0] ref_a [ROWS][INNER];
  logic [7:0] ref_b [INNER][COLS];
  int         ref_beats;
  bit         ref_start, ref_wait, ref_err, ref_done_prev, ref_acc;
  logic [7:0] frame [A_BYTES + B_BYTES];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_ready();
    return !rst && !ref_wait && !ref_start;
  endfunction

  task automatic ref_clear();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < INNER; c++) ref_a[r][c] = 8'd0;
    for (int r = 0; r < INNER; r++) for (int c = 0; c < COLS; c++) ref_b[r][c] = 8'd0;
    ref_beats = 0; ref_start = 0; ref_wait = 0; ref_err = 0;
  endtask

  task automatic ref_step();
    bit new_err;
    int off;
    new_err = 0;
    ref_acc = 0;
    if (rst) begin
      ref_clear();
    end else begin
      ref_acc = bus.in_valid && ref_ready();
      if (ref_start) begin
        ref_start = 0;
        ref_wait  = 1;
      end else if (ref_wait) begin
        if (mm_done && !ref_done_prev) ref_wait = 0;
      end else if (ref_acc) begin
        for (int k = 0; k < BUS_BYTES; k++) begin
          off = ref_beats * BUS_BYTES + k;
          if (off < A_BYTES) ref_a[off / INNER][off % INNER] = bus.in_data[8*k +: 8];
          else ref_b[(off - A_BYTES) / COLS][(off - A_BYTES) % COLS] = bus.in_data[8*k +: 8];
        end
        if (bus.in_last != (ref_beats == F_BEATS - 1)) begin
          new_err = 1;
          ref_beats = 0;
        end else if (ref_beats == F_BEATS - 1) begin
          ref_beats = 0;
          ref_start = 1;
        end else begin
          ref_beats++;
        end
      end
      if (new_err) ref_err = 1;
      else if (err_clr) ref_err = 0;
    end
    ref_done_prev = mm_done;
  endtask

  task automatic chk_mats();
    logic [31:0] g, e;
    string t;
    g = {24'd0, a_mat[0][0]}; e = {24'd0, ref_a[0][0]}; t = "a_mat";
    for (int r = ROWS - 1; r >= 0; r--)
      for (int c = INNER - 1; c >= 0; c--)
        if (a_mat[r][c] !== ref_a[r][c]) begin
          g = {24'd0, a_mat[r][c]}; e = {24'd0, ref_a[r][c]};
          t = $sformatf("a_mat[%0d][%0d]", r, c);
        end
    chk(t, g, e);
    g = {24'd0, b_mat[0][0]}; e = {24'd0, ref_b[0][0]}; t = "b_mat";
    for (int r = INNER - 1; r >= 0; r--)
      for (int c = COLS - 1; c >= 0; c--)
        if (b_mat[r][c] !== ref_b[r][c]) begin
          g = {24'd0, b_mat[r][c]}; e = {24'd0, ref_b[r][c]};
          t = $sformatf("b_mat[%0d][%0d]", r, c);
        end
    chk(t, g, e);
  endtask

  task automatic step();
    @(negedge clk);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, ref_ready()});
    chk("mm_start", {31'd0, mm_start}, {31'd0, ref_start});
    chk("busy", {31'd0, busy}, {31'd0, (ref_beats != 0) || ref_start || ref_wait});
    chk("err", {31'd0, err}, {31'd0, ref_err});
    chk_mats();
    @(posedge clk);
    ref_step();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic put_beat(input int b, input bit last);
    int guard;
    guard = 0;
    for (int k = 0; k < BUS_BYTES; k++) bus.in_data[8*k +: 8] = frame[b * BUS_BYTES + k];
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    do begin
      step();
      guard++;
    end while (!ref_acc && guard < 200);
    if (!ref_acc) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // bad_at: beat index carrying a premature in_last (-1 for none); stop_after: beats to send.
  task automatic send_frame(input int bad_at, input bit drop_last, input bit gaps, input int stop_after);
    bit last;
    for (int b = 0; b < stop_after; b++) begin
      if (gaps) idle_cycles($urandom_range(0, 1));
      last = (b == F_BEATS - 1);
      if (b == bad_at) last = 1'b1;
      if (drop_last && b == F_BEATS - 1) last = 1'b0;
      put_beat(b, last);
      if (b == bad_at) break;
    end
  endtask

  task automatic fill_pattern();
    for (int n = 0; n < A_BYTES; n++) frame[n] = 8'(n % 256);
    for (int n = 0; n < B_BYTES; n++) frame[A_BYTES + n] = 8'(255 - n);
  endtask

  task automatic fill_random();
    for (int n = 0; n < A_BYTES + B_BYTES; n++) frame[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_done();
    mm_done = 1'b0;
    idle_cycles(3);
    mm_done = 1'b1;
    idle_cycles(2);
    mm_done = 1'b0;
    idle_cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mm_done = 1'b0; err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    ref_clear();
    ref_done_prev = 0;
    ref_acc = 0;

    // Reset held three cycles, then in_ready the cycle after release.
    @(posedge clk); ref_step(); #1;
    step(); step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    // Happy path with the fixed byte pattern.
    fill_pattern();
    send_frame(-1, 0, 0, F_BEATS);
    chk("a_1_5", {24'd0, a_mat[1][5]}, 32'd37);
    chk("b_31_3", {24'd0, b_mat[31][3]}, 32'd128);
    chk("start_after_last", {31'd0, mm_start}, 32'd1);
    run_done();
    chk("idle_after_done", {31'd0, busy}, 32'd0);

    // Gapped frame, then a second frame offered during WAIT with mm_done left high.
    fill_random();
    send_frame(-1, 0, 1, F_BEATS);
    fill_random();
    for (int k = 0; k < BUS_BYTES; k++) bus.in_data[8*k +: 8] = frame[k];
    bus.in_valid = 1'b1;
    repeat (6) step();
    chk("no_accept_in_wait", {31'd0, bus.in_ready}, 32'd0);
    mm_done = 1'b1;
    send_frame(-1, 0, 1, F_BEATS);

    // Stale done level: stays in WAIT until a fresh rising edge.
    idle_cycles(8);
    chk("stale_done_busy", {31'd0, busy}, 32'd1);
    mm_done = 1'b0;
    idle_cycles(1);
    mm_done = 1'b1;
    idle_cycles(2);
    chk("fresh_done_idle", {31'd0, busy}, 32'd0);
    mm_done = 1'b0;

    // Framing errors and sticky err handling.
    fill_random();
    send_frame(4, 0, 0, F_BEATS);
    chk("err_early_last", {31'd0, err}, 32'd1);
    chk("busy_after_err", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    idle_cycles(1);
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
    send_frame(-1, 1, 0, F_BEATS);
    chk("err_missing_last", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    send_frame(0, 0, 0, F_BEATS);
    err_clr = 1'b0;
    chk("err_beats_clr", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    idle_cycles(1);
    err_clr = 1'b0;

    // Reset mid-frame discards everything; next frame loads cleanly.
    fill_random();
    send_frame(-1, 0, 0, 10);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    chk("a_zero_after_rst", {24'd0, a_mat[0][0]}, 32'd0);
    fill_random();
    send_frame(-1, 0, 1, F_BEATS);
    run_done();

    // Random mix of good and faulty frames.
    for (int i = 0; i < 8; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      err_clr = 1'($urandom_range(0, 1));
      fill_random();
      if (kind == 0) send_frame($urandom_range(0, F_BEATS - 2), 0, 1, F_BEATS);
      else if (kind == 1) send_frame(-1, 1, 1, F_BEATS);
      else begin
        send_frame(-1, 0, 1, F_BEATS);
        run_done();
      end
      err_clr = 1'b0;
      idle_cycles(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
